// File: rtl/ula_pkg.sv
// ula_pkg: definitions shared by the multicycle ALU and its mult/div engine.
//   - 5-bit operation codes (OP_SLL .. OP_DIVU)
//   - control FSM state type
//   - helpers that classify the mult/div operation codes
package ula_pkg;

   localparam logic [4:0] OP_SLL   = 5'h00;
   localparam logic [4:0] OP_SRL   = 5'h01;
   localparam logic [4:0] OP_SRA   = 5'h02;
   localparam logic [4:0] OP_SLLV  = 5'h03;
   localparam logic [4:0] OP_SRLV  = 5'h04;
   localparam logic [4:0] OP_SRAV  = 5'h05;
   localparam logic [4:0] OP_ADD   = 5'h06;
   localparam logic [4:0] OP_SUB   = 5'h07;
   localparam logic [4:0] OP_AND   = 5'h08;
   localparam logic [4:0] OP_OR    = 5'h09;
   localparam logic [4:0] OP_XOR   = 5'h0A;
   localparam logic [4:0] OP_NOR   = 5'h0B;
   localparam logic [4:0] OP_SLT   = 5'h0C;
   localparam logic [4:0] OP_SLTU  = 5'h0D;
   localparam logic [4:0] OP_LUI   = 5'h0E;
   localparam logic [4:0] OP_MULT  = 5'h10;
   localparam logic [4:0] OP_MULTU = 5'h11;
   localparam logic [4:0] OP_DIV   = 5'h12;
   localparam logic [4:0] OP_DIVU  = 5'h13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_t;

   // True for mult/multu/div/divu (codes 0x10..0x13).
   function automatic logic is_muldiv(input logic [4:0] op);
      return (op[4:2] == 3'b100);
   endfunction

   // Within the mult/div group: bit 1 selects divide, bit 0 selects unsigned.
   function automatic logic muldiv_is_div(input logic [4:0] op);
      return op[1];
   endfunction

   function automatic logic muldiv_is_signed(input logic [4:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// ula_muldiv_iter: iterative multiply / restoring divide engine.
//   load      : capture operand magnitudes and result signs
//   step      : one shift-add (mult) or shift-subtract (div) iteration
//   fix       : apply sign correction and write hi/lo
//   is_div    : divide when 1, multiply when 0 (sampled on load)
//   is_signed : treat operands as two's complement (sampled on load)
//   a         : in1 (multiplicand / divisor)
//   b         : in2 (multiplier / dividend)
//   hi, lo    : registered HI/LO
//   lo_fix    : value lo will take on the fix cycle
//   dbz       : current operation is a divide by zero
module ula_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             fix,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] lo_fix,
   output logic             dbz
);

   logic [WIDTH-1:0] dvs_reg;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc_reg;    // product high half / partial remainder
   logic [WIDTH-1:0] q_reg;      // multiplier / dividend, becomes lo / quotient
   logic             div_reg;
   logic             neg_q_reg;  // negate product or quotient
   logic             neg_r_reg;  // negate remainder (dividend sign)
   logic             dbz_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   add_sum, shl_rem, trial;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] hi_fix;

   always_comb begin
      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;

      add_sum = {1'b0, acc_reg} + {1'b0, (q_reg[0] ? dvs_reg : {WIDTH{1'b0}})};
      shl_rem = {acc_reg, q_reg[WIDTH-1]};
      trial   = shl_rem - {1'b0, dvs_reg};

      prod     = {acc_reg, q_reg};
      prod_fix = neg_q_reg ? -prod : prod;

      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
      if (dbz_reg) begin
         // steps were skipped, so q_reg still holds the raw dividend
         hi_fix = q_reg;
         lo_fix = {WIDTH{1'b1}};
      end else if (div_reg) begin
         hi_fix = neg_r_reg ? -acc_reg : acc_reg;
         lo_fix = neg_q_reg ? -q_reg : q_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dvs_reg   <= '0;
         acc_reg   <= '0;
         q_reg     <= '0;
         div_reg   <= 1'b0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         dbz_reg   <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else if (load) begin
         dvs_reg   <= a_mag;
         acc_reg   <= '0;
         div_reg   <= is_div;
         neg_q_reg <= a_neg ^ b_neg;
         neg_r_reg <= b_neg;
         dbz_reg   <= is_div && (a == '0);
         q_reg     <= (is_div && (a == '0)) ? b : b_mag;
      end else if (step && !dbz_reg) begin
         if (div_reg) begin
            if (!trial[WIDTH]) begin
               acc_reg <= trial[WIDTH-1:0];
               q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
               acc_reg <= shl_rem[WIDTH-1:0];
               q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_reg <= add_sum[WIDTH:1];
            q_reg   <= {add_sum[0], q_reg[WIDTH-1:1]};
         end
      end else if (fix) begin
         hi_reg <= hi_fix;
         lo_reg <= lo_fix;
      end
   end

   assign hi  = hi_reg;
   assign lo  = lo_reg;
   assign dbz = dbz_reg;

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ALU for the multicycle MIPS datapath.
//   start/op/in1/in2 : request, sampled only while busy=0
//   result, zero     : registered result and result==0
//   hi, lo           : HI/LO from mult/div
//   overflow         : signed overflow of add/sub
//   div_by_zero      : last div/divu had in1==0
//   busy, done       : engine running / one-cycle completion pulse
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_reg, overflow_reg, dbz_flag_reg, done_reg;

   logic             eng_load, eng_step, eng_fix, eng_dbz;
   logic [WIDTH-1:0] eng_lo_fix;

   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] sum, diff, alu;
   logic             ov;

   assign sh   = in2[SHW-1:0];
   assign sum  = in2 + in1;
   assign diff = in2 - in1;

   always_comb begin
      alu = '0;
      ov  = 1'b0;
      case (op)
         OP_SLL, OP_SLLV: alu = in1 << sh;
         OP_SRL, OP_SRLV: alu = in1 >> sh;
         OP_SRA, OP_SRAV: alu = $signed(in1) >>> sh;
         OP_ADD: begin
            alu = sum;
            ov  = (in2[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in2[WIDTH-1]);
         end
         OP_SUB: begin
            alu = diff;
            ov  = (in2[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in2[WIDTH-1]);
         end
         OP_AND:  alu = in2 & in1;
         OP_OR:   alu = in2 | in1;
         OP_XOR:  alu = in2 ^ in1;
         OP_NOR:  alu = ~(in2 | in1);
         OP_SLT:  alu = {{(WIDTH-1){1'b0}}, ($signed(in2) < $signed(in1))};
         OP_SLTU: alu = {{(WIDTH-1){1'b0}}, (in2 < in1)};
         OP_LUI:  alu = {in1[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default: alu = '0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      eng_load   = 1'b0;
      eng_step   = 1'b0;
      eng_fix    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && is_muldiv(op)) begin
               eng_load   = 1'b1;
               state_next = ITER;
            end
         end
         ITER: begin
            eng_step = 1'b1;
            if (count_reg == CW'(WIDTH-1)) state_next = FIX;
         end
         FIX: begin
            eng_fix    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         result_reg   <= '0;
         zero_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         dbz_flag_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  overflow_reg <= ov;
                  dbz_flag_reg <= 1'b0;
                  count_reg    <= '0;
                  if (!is_muldiv(op)) begin
                     result_reg <= alu;
                     zero_reg   <= (alu == '0);
                     done_reg   <= 1'b1;
                  end
               end
            end
            ITER: count_reg <= count_reg + 1'b1;
            FIX: begin
               result_reg   <= eng_lo_fix;
               zero_reg     <= (eng_lo_fix == '0);
               dbz_flag_reg <= eng_dbz;
               done_reg     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   ula_muldiv_iter #(.WIDTH(WIDTH)) u_engine (
      .clk       (clk),
      .reset     (reset),
      .load      (eng_load),
      .step      (eng_step),
      .fix       (eng_fix),
      .is_div    (muldiv_is_div(op)),
      .is_signed (muldiv_is_signed(op)),
      .a         (in1),
      .b         (in2),
      .hi        (hi),
      .lo        (lo),
      .lo_fix    (eng_lo_fix),
      .dbz       (eng_dbz)
   );

   assign result      = result_reg;
   assign zero        = zero_reg;
   assign overflow    = overflow_reg;
   assign div_by_zero = dbz_flag_reg;
   assign done        = done_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_ula_multiciclo.sv
module tb_ula_multiciclo;
   import ula_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [4:0]  op;
   logic [31:0] in1, in2;
   logic [31:0] result, hi, lo;
   logic        zero, overflow, div_by_zero, busy, done;

   int errors = 0;
   int checks = 0;
   int nb, nd, doff;

   always #5 clk = ~clk;

   ula_multiciclo #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .in1         (in1),
      .in2         (in2),
      .result      (result),
      .hi          (hi),
      .lo          (lo),
      .zero        (zero),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Pulse start for one edge, then scramble operands; returns at the
   // falling edge right after the accepting rising edge.
   task automatic issue(input logic [4:0] o, input logic [31:0] b, input logic [31:0] a);
      start = 1'b1; op = o; in2 = b; in1 = a;
      @(negedge clk);
      start = 1'b0; in1 = $urandom; in2 = $urandom; op = 5'($urandom);
   endtask

   // Observe ncyc cycles counting busy cycles and done pulses; optionally
   // pulse an add start at cycle poke_at.
   task automatic watch(input int ncyc, input int poke_at);
      nb = 0; nd = 0; doff = -1;
      for (int c = 0; c < ncyc; c++) begin
         if (busy) nb++;
         if (done) begin nd++; doff = c; end
         if (c == poke_at) begin
            start = 1'b1; op = OP_ADD; in2 = 32'd200; in1 = 32'd100;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic single(input string tag, input logic [4:0] o, input logic [31:0] b,
                         input logic [31:0] a, input logic [31:0] exp);
      issue(o, b, a);
      chk(tag, result, exp);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done0"}, done, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_result", result, 0);
      chk("rst_hilo", hi | lo, 0);
      chk("rst_flags", {zero, overflow, div_by_zero, busy, done}, 0);

      // add with signed overflow
      issue(OP_ADD, 32'h7FFFFFFF, 32'd1);
      chk("add_res", result, 32'h80000000);
      chk("add_ovf", overflow, 1);
      chk("add_zero", zero, 0);
      chk("add_done", done, 1);
      chk("add_busy", busy, 0);
      @(negedge clk);
      chk("add_done0", done, 0);
      chk("add_busy0", busy, 0);

      single("srav", OP_SRAV, 32'd4, 32'h80000000, 32'hF8000000);
      chk("srav_ovf", overflow, 0);
      single("srl", OP_SRL, 32'd4, 32'h80000000, 32'h08000000);
      single("sltu", OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'd1);
      single("slt", OP_SLT, 32'd1, 32'hFFFFFFFF, 32'd0);
      chk("slt_zero", zero, 1);
      single("sub", OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF);
      chk("sub_ovf", overflow, 1);
      single("lui", OP_LUI, 32'h0, 32'h1234ABCD, 32'hABCD0000);
      single("nor", OP_NOR, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00);
      single("undef", 5'h1F, 32'h1234, 32'h5678, 32'h0);

      // signed multiply -3 * 7
      issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
      watch(40, -1);
      chk("mult_busy", nb, 33);
      chk("mult_ndone", nd, 1);
      chk("mult_doff", doff, 33);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFEB);
      chk("mult_res", result, 32'hFFFFFFEB);

      // signed divide -7 / 2
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      watch(40, -1);
      chk("div_doff", doff, 33);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);

      // most-negative / -1
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      watch(40, -1);
      chk("divmn_lo", lo, 32'h80000000);
      chk("divmn_hi", hi, 32'h0);
      chk("divmn_dbz", div_by_zero, 0);

      // divide by zero
      issue(OP_DIVU, 32'd7, 32'd0);
      watch(40, -1);
      chk("dbz_busy", nb, 33);
      chk("dbz_doff", doff, 33);
      chk("dbz_lo", lo, 32'hFFFFFFFF);
      chk("dbz_hi", hi, 32'd7);
      chk("dbz_flag", div_by_zero, 1);

      // flag cleared by another op, hi/lo untouched
      single("and", OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00);
      chk("and_dbz", div_by_zero, 0);
      chk("and_hi", hi, 32'd7);

      // multu with an ignored start mid-operation
      issue(OP_MULTU, 32'd5, 32'd6);
      watch(40, 3);
      chk("mu_ndone", nd, 1);
      chk("mu_lo", lo, 32'd30);
      chk("mu_hi", hi, 32'd0);
      chk("mu_res", result, 32'd30);
      chk("mu_busy", nb, 33);

      // reset in the middle of a divide
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      chk("rd_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rd_busy0", busy, 0);
      chk("rd_result", result, 0);
      chk("rd_hi", hi, 0);
      chk("rd_lo", lo, 0);
      chk("rd_flags", {zero, overflow, div_by_zero, done}, 0);
      watch(40, -1);
      chk("rd_ndone", nd, 0);
      chk("rd_lo2", lo, 0);
      single("add2", OP_ADD, 32'd2, 32'd3, 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
